// File: rtl/sysid_pkg.sv
// sysid_pkg: sequencer states, sysid word addresses and default expected values
package sysid_pkg;
  typedef enum logic [2:0] {
    IDLE,
    RD_ID_REQ,
    RD_ID_LAT,
    RD_TS_REQ,
    RD_TS_LAT,
    COMPARE,
    PERIOD_WAIT
  } state_e;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1430182636;
endpackage

// File: rtl/avmm_single_read.sv
// avmm_single_read: one Avalon-MM read with waitrequest timeout and fixed read latency
module avmm_single_read #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic lat,
  input  logic av_waitrequest,
  output logic av_read,
  output logic accept,
  output logic capture,
  output logic timed_out
);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  always_comb begin
    av_read    = req;
    accept     = req & ~av_waitrequest;
    timed_out  = req & av_waitrequest & (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
    capture    = (READ_LATENCY == 0) ? accept : lat & (lat_cnt_q == 2'(READ_LATENCY));
    wait_cnt_d = (req & av_waitrequest) ? wait_cnt_q + 16'd1 : '0;
    lat_cnt_d  = lat ? lat_cnt_q + 2'd1 : 2'd1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end
endmodule

// File: rtl/sysid_verifier.sv
// sysid_verifier: reads the sysid ID/timestamp words and publishes pass/fail/timeout status
module sysid_verifier
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          PERIOD_CYCLES  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [15:0] check_count
);
  state_e      state_q, state_d;
  logic        to_q, to_d, pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d, done_q, done_d;
  logic [31:0] id_q, id_d, ts_q, ts_d, per_q, per_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req, lat, is_ts, accept, capture, timed_out;
  avmm_single_read #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_read (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .lat           (lat),
    .av_waitrequest(av_waitrequest),
    .av_read       (av_read),
    .accept        (accept),
    .capture       (capture),
    .timed_out     (timed_out)
  );
  always_comb begin
    req        = ~reset & (state_q inside {RD_ID_REQ, RD_TS_REQ});
    lat        = state_q inside {RD_ID_LAT, RD_TS_LAT};
    is_ts      = state_q inside {RD_TS_REQ, RD_TS_LAT};
    av_address = is_ts ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy       = ~reset & ~(state_q inside {IDLE, PERIOD_WAIT});
    state_d    = state_q;
    to_d       = to_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    tmo_d      = tmo_q;
    done_d     = done_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    id_d       = (capture & ~is_ts) ? av_readdata : id_q;
    ts_d       = (capture & is_ts) ? av_readdata : ts_q;
    case (state_q)
      IDLE: state_d = start ? RD_ID_REQ : IDLE;
      RD_ID_REQ, RD_TS_REQ: begin
        to_d = timed_out;
        if (timed_out) state_d = COMPARE;
        else if (accept)
          state_d = (READ_LATENCY != 0) ? (is_ts ? RD_TS_LAT : RD_ID_LAT)
                                        : (is_ts ? COMPARE : RD_TS_REQ);
      end
      RD_ID_LAT: state_d = capture ? RD_TS_REQ : RD_ID_LAT;
      RD_TS_LAT: state_d = capture ? COMPARE : RD_TS_LAT;
      COMPARE: begin
        pass_d  = ~to_q & (id_q == EXPECTED_ID) & (ts_q == EXPECTED_TS);
        fail_d  = ~pass_d;
        tmo_d   = to_q;
        done_d  = 1'b1;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
        per_d   = 32'(PERIOD_CYCLES - 1);
        state_d = (PERIOD_CYCLES == 0) ? IDLE : PERIOD_WAIT;
      end
      PERIOD_WAIT: begin
        per_d   = per_q - 32'd1;
        state_d = (start || per_q == '0) ? RD_ID_REQ : PERIOD_WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RD_ID_REQ;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      per_q   <= '0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end
  always_comb begin
    done        = done_q;
    pass        = pass_q;
    fail        = fail_q;
    timeout     = tmo_q;
    captured_id = id_q;
    captured_ts = ts_q;
    check_count = cnt_q;
  end
endmodule

// File: tb/tb_sysid_verifier.sv
// tb_sysid_verifier: randomized sysid slaves against two verifier builds (latency 0 one-shot,
// latency 2 periodic) with an expected-result scoreboard per build.
module tb_sysid_verifier;
  localparam logic [31:0] EID = 32'h0000_0000;
  localparam logic [31:0] ETS = 32'd1430182636;
  localparam int          TO  = 4;

  typedef struct {
    logic        p, f, t;
    logic [31:0] id, ts;
    logic [15:0] cnt;
    int          len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  av_address, av_read, av_wait, busy, done, pass, fail, tmo;
  logic [31:0] av_rdata [2];
  logic [31:0] cap_id [2];
  logic [31:0] cap_ts [2];
  logic [15:0] cnt [2];
  exp_t        exp_q [2][$];
  logic [31:0] m_id [2];
  logic [31:0] m_ts [2];
  int          m_cnt [2];
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[inst %0d]: got %h, expected %h", name, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int L = 2 * g;
    localparam int P = 10 * g;
    sysid_verifier #(
      .READ_LATENCY  (L),
      .TIMEOUT_CYCLES(TO),
      .PERIOD_CYCLES (P)
    ) dut (
      .clock         (clk),
      .reset         (rst),
      .start         (start),
      .av_address    (av_address[g]),
      .av_read       (av_read[g]),
      .av_waitrequest(av_wait[g]),
      .av_readdata   (av_rdata[g]),
      .busy          (busy[g]),
      .done          (done[g]),
      .pass          (pass[g]),
      .fail          (fail[g]),
      .timeout       (tmo[g]),
      .captured_id   (cap_id[g]),
      .captured_ts   (cap_ts[g]),
      .check_count   (cnt[g])
    );

    // Slave: plans each check (data and stall counts) when its ID read appears.
    initial begin
      int stall, lat, id_st, ts_st;
      bit in_req, good;
      logic [31:0] val, id_v, ts_v;
      exp_t e;
      stall = 0; lat = 0; in_req = 0; good = 1; val = 0; id_v = 0; ts_v = 0; id_st = 0; ts_st = 0;
      av_wait[g] = 1'b0;
      av_rdata[g] = '0;
      forever begin
        @(negedge clk);
        av_wait[g] = 1'($urandom_range(1));
        av_rdata[g] = $urandom;
        if (rst) begin
          in_req = 0; lat = 0; good = 1;
          exp_q[g].delete();
          m_id[g] = '0; m_ts[g] = '0; m_cnt[g] = 0;
        end else if (lat > 0) begin
          lat--;
          if (lat == 0) av_rdata[g] = val;
        end else if (av_read[g]) begin
          if (!in_req) begin
            in_req = 1;
            if (!av_address[g]) begin
              id_st = good ? 0 : $urandom_range(5);
              ts_st = good ? 0 : $urandom_range(5);
              id_v = (good || $urandom_range(2) != 0) ? EID : EID ^ (32'd1 << $urandom_range(31));
              ts_v = (good || $urandom_range(2) != 0) ? ETS : ETS ^ (32'd1 << $urandom_range(31));
              good = 0;
              m_cnt[g] = (m_cnt[g] < 65535) ? m_cnt[g] + 1 : m_cnt[g];
              e.t = 1'b0;
              if (id_st >= TO) begin
                e.t = 1'b1;
                e.len = TO + 1;
              end else begin
                m_id[g] = id_v;
                e.len = id_st + 1 + L;
                if (ts_st >= TO) begin
                  e.t = 1'b1;
                  e.len += TO + 1;
                end else begin
                  m_ts[g] = ts_v;
                  e.len += ts_st + 1 + L + 1;
                end
              end
              e.p = !e.t && m_id[g] == EID && m_ts[g] == ETS;
              e.f = !e.p;
              e.id = m_id[g];
              e.ts = m_ts[g];
              e.cnt = 16'(m_cnt[g]);
              exp_q[g].push_back(e);
            end
            stall = av_address[g] ? ts_st : id_st;
            val = av_address[g] ? ts_v : id_v;
          end
          if (stall > 0) begin
            av_wait[g] = 1'b1;
            stall--;
          end else begin
            av_wait[g] = 1'b0;
            in_req = 0;
            if (L == 0) av_rdata[g] = val;
            else lat = L;
          end
        end else begin
          in_req = 0;
        end
      end
    end

    // Monitor: checks sequence starts are legitimate and scores every completed check.
    initial begin
      int run, idle;
      bit first, exp_next, bp;
      logic [15:0] pc;
      exp_t e;
      run = 0; idle = 0; first = 1; exp_next = 0; bp = 0; pc = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          run = 0; idle = 0; first = 1; exp_next = 0; bp = 0; pc = '0;
        end else begin
          if (first || exp_next || (busy[g] && !bp))
            chk("seq_start", g, 32'(busy[g] && !bp), 32'(first || exp_next));
          first = 0;
          if (cnt[g] != pc) begin
            if (exp_q[g].size() == 0) begin
              chk("unexpected_done", g, 32'(cnt[g]), 32'(pc));
            end else begin
              e = exp_q[g].pop_front();
              chk("pass", g, 32'(pass[g]), 32'(e.p));
              chk("fail", g, 32'(fail[g]), 32'(e.f));
              chk("timeout", g, 32'(tmo[g]), 32'(e.t));
              chk("done", g, 32'(done[g]), 32'd1);
              chk("captured_id", g, cap_id[g], e.id);
              chk("captured_ts", g, cap_ts[g], e.ts);
              chk("check_count", g, 32'(cnt[g]), 32'(e.cnt));
              chk("busy_cycles", g, 32'(run), 32'(e.len));
            end
          end
          run = busy[g] ? run + 1 : 0;
          idle = busy[g] ? 0 : idle + 1;
          exp_next = !busy[g] && (start || (P > 0 && idle == P));
          pc = cnt[g];
          bp = busy[g];
        end
      end
    end
  end

  task automatic zero_chk();
    for (int i = 0; i < 2; i++) begin
      chk("rst_av_read", i, 32'(av_read[i]), 32'd0);
      chk("rst_av_address", i, 32'(av_address[i]), 32'd0);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_done", i, 32'(done[i]), 32'd0);
      chk("rst_pass", i, 32'(pass[i]), 32'd0);
      chk("rst_fail", i, 32'(fail[i]), 32'd0);
      chk("rst_timeout", i, 32'(tmo[i]), 32'd0);
      chk("rst_captured_id", i, cap_id[i], 32'd0);
      chk("rst_captured_ts", i, cap_ts[i], 32'd0);
      chk("rst_check_count", i, 32'(cnt[i]), 32'd0);
    end
  endtask

  task automatic run_random(input int n);
    repeat (n) begin
      @(posedge clk);
      #2 start = ($urandom_range(7) == 0);
    end
    start = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 zero_chk();
    @(posedge clk);
    #2 rst = 1'b0;
    run_random(3000);
    k = 0;
    while (!(busy[1] && av_address[1] && !av_read[1]) && k < 500) begin
      @(posedge clk);
      #1 k++;
    end
    chk("reach_ts_lat", 1, 32'(k < 500), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 zero_chk();
    @(posedge clk);
    #2 rst = 1'b0;
    run_random(1500);
    k = 0;
    while ((busy[0] || busy[1]) && k < 300) begin
      @(posedge clk);
      #1 k++;
    end
    chk("drain", 0, 32'(k < 300), 32'd1);
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk("outstanding_checks", i, 32'(exp_q[i].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sysid_verifier.md
Name: sysid_verifier

Overview:
- Avalon-MM host that reads the system-ID slave's two words and compares them against build-time expected values: address 0 holds the ID, address 1 the timestamp.
- Sits directly upstream of the sysid slave, driving its address and consuming its readdata.
- Publishes pass/fail/timeout status for boot gating (e.g. hold the Nios/SPI subsystem until the hardware image matches the software).
- Runs once after reset, on request, and optionally at a fixed period.

Parameters:
- EXPECTED_ID, 32'h00000000: expected word at address 0.
- EXPECTED_TS, 32'd1430182636: expected word at address 1.
- READ_LATENCY, 0: cycles from the accepted read to valid readdata. Legal range 0..3; 0 means readdata is sampled in the accept cycle.
- TIMEOUT_CYCLES, 255: maximum consecutive waitrequest cycles per read before the check is abandoned. Legal range 1..65535.
- PERIOD_CYCLES, 0: idle cycles between automatic rechecks. 0 means one-shot.

Ports:
- clock, input, 1: sole clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle request to rerun the check. Ignored while busy.
- av_address, output, 1: word select to the sysid slave.
- av_read, output, 1: read strobe.
- av_waitrequest, input, 1: slave stall. Tie to 0 for a zero-wait slave.
- av_readdata, input, 32: slave read data.
- busy, output, 1: a check sequence is in progress.
- done, output, 1: at least one check has completed since reset.
- pass, output, 1: last check matched both words and did not time out.
- fail, output, 1: last check mismatched or timed out.
- timeout, output, 1: last check aborted on waitrequest.
- captured_id, output, 32: ID word read in the last check.
- captured_ts, output, 32: timestamp word read in the last check.
- check_count, output, 16: completed checks. Saturates at 16'hFFFF.

Behaviour:
- Clocking and reset (decided): one clock, `clock`; synchronous active-high `reset`.
- While reset is high, all outputs are 0, the FSM is in RD_ID_REQ, and all counters are cleared.
- The first check starts automatically on the first cycle after reset deasserts.
- Reset mid-sequence aborts the read immediately. av_read is 0 in the cycle after reset is sampled.

FSM states:
- IDLE, RD_ID_REQ, RD_ID_LAT, RD_TS_REQ, RD_TS_LAT, COMPARE, PERIOD_WAIT.

Read request states (RD_x_REQ):
- av_read=1; av_address is 0 for ID, 1 for TS.
- The read is accepted in the first cycle with av_waitrequest=0.
- wait_cnt counts stalled cycles. When wait_cnt reaches TIMEOUT_CYCLES, go to COMPARE with timeout forced.
- On accept with READ_LATENCY=0: capture av_readdata in that cycle, then advance to the next REQ state (or COMPARE after TS).
- On accept with READ_LATENCY>0: go to RD_x_LAT. av_read=0 there.

Latency states (RD_x_LAT):
- lat_cnt counts 1..READ_LATENCY.
- Capture av_readdata on the cycle lat_cnt==READ_LATENCY, then advance.

COMPARE (one cycle) updates outputs:
- pass = !to & (captured_id==EXPECTED_ID) & (captured_ts==EXPECTED_TS).
- fail = !pass.
- timeout = to.
- done = 1.
- check_count increments, saturating.
- On timeout the unread capture registers hold their previous values.
- Next state: IDLE if PERIOD_CYCLES==0, else PERIOD_WAIT.

PERIOD_WAIT:
- Down-counts PERIOD_CYCLES; at zero, go to RD_ID_REQ.
- start here triggers an immediate recheck.

IDLE:
- start goes to RD_ID_REQ.

Output timing:
- busy = 1 in the REQ, LAT and COMPARE states.
- pass/fail/timeout hold their previous values during a recheck; they are not cleared at sequence start.
- start coinciding with the COMPARE cycle is ignored.

Latency, zero-wait slave with READ_LATENCY=0:
- Two read cycles plus one COMPARE.
- Status is valid 3 cycles after the first read is issued.

Decomposition:
- Shared package `sysid_pkg`:
  - state enum;
  - SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1;
  - default expected ID and timestamp constants, shared with the slave generator.
- One natural sub-module, `avmm_single_read`: one Avalon read with waitrequest timeout and fixed read latency. Instantiated once and reused for both words.
- The top level holds sequencing, comparison and the period timer.

Test Plan:
1. Zero-wait slave with readdata = address ? 1430182636 : 0, reset released -> reads at cycles 1 and 2; pass=1, fail=0, done=1 at cycle 3; captured_ts=1430182636; check_count=1.
2. Slave returns TS=1430182637 -> fail=1, pass=0, timeout=0; captured_ts=1430182637.
3. waitrequest held high, TIMEOUT_CYCLES=4 -> av_read high for exactly 4 cycles, then timeout=1, fail=1, busy=0; captured values unchanged.
4. READ_LATENCY=2 slave with correct data -> capture 2 cycles after each accept; pass=1 after 7 cycles total; av_read is a single-cycle pulse per word.
5. PERIOD_CYCLES=10 -> second read sequence begins 10 cycles after the first COMPARE; check_count=2 after the second; start pulsed while busy has no effect.
6. reset asserted while in RD_TS_LAT -> next cycle: all outputs 0, av_read=0; after release, a fresh check passes.
